mul_div_unit: RTL and testbench

//  Iterative 32x32 multiply/divide unit with architectural HI/LO registers for the MIPS150 execute stage.

---
 rtl/mul_div_pkg.sv | 26 ++
 rtl/mul_div_step.sv | 39 +++
 rtl/mul_div_unit.sv | 174 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared constants for the MIPS150 multiply/divide unit: Op encodings,
// FSM state type and a small decode helper.
package mul_div_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITERS = 32;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIN  = 2'd2
  } md_state_e;

  // Signed ops work on magnitudes and are sign-corrected on completion.
  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the iterative multiplier/divider on the {hi, lo} pair.
//   mul: right-shift shift-add; lo holds the multiplier, operand the multiplicand.
//   div: restoring shift-subtract; hi holds the partial remainder, lo the
//        dividend shifting out / quotient shifting in, operand the divisor.
module mul_div_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  // Both datapaths are evaluated; is_div picks the result.
  always_comb begin
    sum    = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
    rem_sh = {hi_in, lo_in[WIDTH-1]};
    // Only used when rem_sh >= operand, so the true difference fits in WIDTH bits.
    diff   = rem_sh[WIDTH-1:0] - operand;
    hi_out = sum[WIDTH:1];
    lo_out = {sum[0], lo_in[WIDTH-1:1]};
    if (is_div) begin
      if (rem_sh >= {1'b0, operand}) begin
        hi_out = diff;
        lo_out = {lo_in[WIDTH-2:0], 1'b1};
      end else begin
        hi_out = rem_sh[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply/divide unit with architectural HI/LO registers.
// Build option: define MULDIV_DIV_EN to include DIV/DIVU; without it those
// opcodes are rejected like any unknown Op (Illegal pulse, no Busy).
//
// Handshake: Start is a request qualified only in IDLE. When Start is high at
// a rising edge in IDLE the request (Op/A/B) is taken at that edge; at any
// other time Start is ignored and nothing is queued, so control must hold the
// pipeline while Busy is high. Done is a one-cycle pulse in the cycle HI/LO
// first show a mul/div result; Illegal is a one-cycle pulse the cycle after an
// unsupported Op was taken.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITERS = MD_ITERS
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             Illegal,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [1:0]       dbg_state
);

`ifdef MULDIV_DIV_EN
  localparam logic DIV_EN = 1'b1;
`else
  localparam logic DIV_EN = 1'b0;
`endif

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  md_state_e state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   work_hi, work_lo, operand, a_orig;
  logic               op_div, neg_q, neg_r, div_zero;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               accept_md, accept_mthi, accept_mtlo, accept_bad, req_div;
  logic               a_neg, b_neg, last_iter;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic               illegal_q;

  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (op_div),
    .hi_in   (work_hi),
    .lo_in   (work_lo),
    .operand (operand),
    .hi_out  (step_hi),
    .lo_out  (step_lo)
  );

  // Request decode: classify a Start seen in IDLE and form operand magnitudes.
  always_comb begin
    accept_md   = 1'b0;
    accept_mthi = 1'b0;
    accept_mtlo = 1'b0;
    accept_bad  = 1'b0;
    req_div     = 1'b0;
    a_neg       = md_is_signed(Op) & A[WIDTH-1];
    b_neg       = md_is_signed(Op) & B[WIDTH-1];
    a_mag       = a_neg ? -A : A;
    b_mag       = b_neg ? -B : B;
    if (Start && (state == MD_IDLE)) begin
      case (Op)
        MD_MULT, MD_MULTU: accept_md = 1'b1;
        MD_DIV, MD_DIVU: begin
          if (DIV_EN) begin
            accept_md = 1'b1;
            req_div   = 1'b1;
          end else begin
            accept_bad = 1'b1;
          end
        end
        MD_MTHI: accept_mthi = 1'b1;
        MD_MTLO: accept_mtlo = 1'b1;
        default: accept_bad = 1'b1;
      endcase
    end
  end

  // Sign/zero fix-up of the final step result, written to HI/LO on entry to FIN.
  always_comb begin
    prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    q_fix    = div_zero ? '1 : (neg_q ? -step_lo : step_lo);
    r_fix    = div_zero ? a_orig : (neg_r ? -step_hi : step_hi);
  end

  // FSM state register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= MD_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and status outputs.
  always_comb begin
    state_nxt = state;
    last_iter = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      MD_IDLE: if (accept_md) state_nxt = MD_RUN;
      MD_RUN: begin
        Busy      = 1'b1;
        last_iter = (cnt == LAST);
        if (last_iter) state_nxt = MD_FIN;
      end
      MD_FIN: begin
        Done      = 1'b1;
        state_nxt = MD_IDLE;
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  // Datapath: MT* writes, operand capture, iteration, and final HI/LO update.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      HI        <= '0;
      LO        <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      operand   <= '0;
      a_orig    <= '0;
      cnt       <= '0;
      op_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept_bad;
      if (accept_mthi) HI <= A;
      if (accept_mtlo) LO <= A;
      if (accept_md) begin
        cnt      <= '0;
        work_hi  <= '0;
        work_lo  <= req_div ? a_mag : b_mag;
        operand  <= req_div ? b_mag : a_mag;
        a_orig   <= A;
        op_div   <= req_div;
        neg_q    <= a_neg ^ b_neg;
        neg_r    <= a_neg;
        div_zero <= (B == '0);
      end else if (state == MD_RUN) begin
        cnt     <= cnt + 1'b1;
        work_hi <= step_hi;
        work_lo <= step_lo;
        if (last_iter) begin
          if (op_div) begin
            HI <= r_fix;
            LO <= q_fix;
          end else begin
            HI <= prod_fix[2*WIDTH-1:WIDTH];
            LO <= prod_fix[WIDTH-1:0];
          end
        end
      end
    end
  end

  assign Illegal   = illegal_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: reset, MT*, multiply, divide (or its
// rejection when the divider is not built), illegal ops, reset abort and
// Start-while-busy.
module tb_mul_div_unit;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_BAD   = 3'd7;

  logic        Clock, Reset, Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done, Illegal;
  logic [31:0] HI, LO;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mul_div_unit dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Op        (Op),
    .A         (A),
    .B         (B),
    .Busy      (Busy),
    .Done      (Done),
    .Illegal   (Illegal),
    .HI        (HI),
    .LO        (LO),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: present a request for one edge; returns #1 after that edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clock);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  task automatic step_cycle();
    @(posedge Clock); #1;
  endtask

  // Waits (bounded) for Done; cycle 1 is the cycle right after the Start edge.
  task automatic wait_done(output int busy_cnt, output int done_at,
                           output logic [31:0] hi_mid, output logic [31:0] lo_mid);
    busy_cnt = 0; done_at = 0; hi_mid = HI; lo_mid = LO;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (Done === 1'b1) begin
        done_at = cyc;
        break;
      end
      if (Busy === 1'b1) busy_cnt++;
      if (cyc == 16) begin
        hi_mid = HI; lo_mid = LO;
      end
      step_cycle();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Op = 3'd0; A = '0; B = '0;
    repeat (3) @(posedge Clock);
    #1;
    @(negedge Clock); Reset = 1'b0;
    step_cycle();
    n_checks++;
    if ({Busy, Done, Illegal} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {Busy, Done, Illegal});
    end
    n_checks++;
    if ({HI, LO} !== 64'h0) begin
      n_fail++; $display("FAIL reset_hilo: got %h_%h want 0_0", HI, LO);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
  endtask

  task automatic test_mt();
    start_op(OP_MTHI, 32'hA5A5_0001, 32'h0);
    n_checks++;
    if (HI !== 32'hA5A5_0001 || Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++; $display("FAIL mthi: got HI=%h busy=%b done=%b want HI=a5a50001 busy=0 done=0", HI, Busy, Done);
    end
    start_op(OP_MTLO, 32'h0000_1234, 32'h0);
    n_checks++;
    if ({HI, LO} !== 64'hA5A5_0001_0000_1234) begin
      n_fail++; $display("FAIL mtlo: got %h_%h want a5a50001_00001234", HI, LO);
    end
  endtask

  task automatic test_multu_latency();
    int bc, da;
    logic [31:0] hm, lm;
    start_op(OP_MTHI, 32'h1111_1111, 32'h0);
    start_op(OP_MTLO, 32'h2222_2222, 32'h0);
    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_checks++;
    if (dbg_state !== 2'd1) begin
      n_fail++; $display("FAIL multu_run_state: got %0d want 1", dbg_state);
    end
    wait_done(bc, da, hm, lm);
    n_checks++;
    if (bc !== 32) begin
      n_fail++; $display("FAIL multu_busy_cycles: got %0d want 32", bc);
    end
    n_checks++;
    if (da !== 33) begin
      n_fail++; $display("FAIL multu_done_cycle: got %0d want 33", da);
    end
    n_checks++;
    if ({hm, lm} !== 64'h1111_1111_2222_2222) begin
      n_fail++; $display("FAIL multu_hold_in_run: got %h_%h want 11111111_22222222", hm, lm);
    end
    n_checks++;
    if ({HI, LO} !== 64'hFFFF_FFFE_0000_0001) begin
      n_fail++; $display("FAIL multu_result: got %h_%h want fffffffe_00000001", HI, LO);
    end
    step_cycle();
    n_checks++;
    if ({Busy, Done, Illegal} !== 3'b000) begin
      n_fail++; $display("FAIL multu_done_pulse: got %b want 000", {Busy, Done, Illegal});
    end
  endtask

  task automatic test_mult();
    int bc, da;
    logic [31:0] hm, lm;
    logic [2:0]  ops  [4] = '{OP_MULT, OP_MULT, OP_MULTU, OP_MULT};
    logic [31:0] av   [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h0001_0000, 32'h7FFF_FFFF};
    logic [31:0] bv   [4] = '{32'h0000_0007, 32'h8000_0000, 32'h0001_0000, 32'hFFFF_FFFF};
    logic [63:0] expv [4] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000,
                              64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001};
    for (int i = 0; i < 4; i++) begin
      start_op(ops[i], av[i], bv[i]);
      wait_done(bc, da, hm, lm);
      n_checks++;
      if (da !== 33 || {HI, LO} !== expv[i]) begin
        n_fail++; $display("FAIL mult_vec%0d: got done@%0d %h_%h want done@33 %h", i, da, HI, LO, expv[i]);
      end
      step_cycle();
    end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    int bc, da;
    logic [31:0] hm, lm;
    logic [2:0]  ops  [6] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
    logic [31:0] av   [6] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd100, 32'd7, 32'hFFFF_FFFB};
    logic [31:0] bv   [6] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFE, 32'd0};
    // {HI (remainder), LO (quotient)}
    logic [63:0] expv [6] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0064_FFFF_FFFF,
                              64'h0000_0000_8000_0000, 64'h0000_0002_0000_000E,
                              64'h0000_0001_FFFF_FFFD, 64'hFFFF_FFFB_FFFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      start_op(ops[i], av[i], bv[i]);
      wait_done(bc, da, hm, lm);
      n_checks++;
      if (da !== 33 || bc !== 32 || {HI, LO} !== expv[i]) begin
        n_fail++; $display("FAIL div_vec%0d: got busy=%0d done@%0d %h_%h want busy=32 done@33 %h",
                           i, bc, da, HI, LO, expv[i]);
      end
      step_cycle();
    end
  endtask
`else
  task automatic test_div_disabled();
    start_op(OP_MTHI, 32'h0000_00AA, 32'h0);
    start_op(OP_MTLO, 32'h0000_00BB, 32'h0);
    start_op(OP_DIV, 32'd9, 32'd3);
    n_checks++;
    if ({Illegal, Busy, Done} !== 3'b100) begin
      n_fail++; $display("FAIL div_disabled_flags: got ill/busy/done=%b want 100", {Illegal, Busy, Done});
    end
    step_cycle();
    n_checks++;
    if (Illegal !== 1'b0 || {HI, LO} !== 64'h0000_00AA_0000_00BB) begin
      n_fail++; $display("FAIL div_disabled_after: got ill=%b %h_%h want ill=0 000000aa_000000bb", Illegal, HI, LO);
    end
  endtask
`endif

  task automatic test_illegal();
    logic [31:0] hi0, lo0;
    start_op(OP_MTLO, 32'h0BAD_F00D, 32'h0);
    hi0 = 32'h0; lo0 = 32'h0BAD_F00D;
    start_op(OP_MTHI, 32'h0000_0042, 32'h0);
    hi0 = 32'h0000_0042;
    start_op(OP_BAD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_checks++;
    if ({Illegal, Busy, Done} !== 3'b100) begin
      n_fail++; $display("FAIL illegal_pulse: got ill/busy/done=%b want 100", {Illegal, Busy, Done});
    end
    step_cycle();
    n_checks++;
    if (Illegal !== 1'b0 || {HI, LO} !== {hi0, lo0}) begin
      n_fail++; $display("FAIL illegal_after: got ill=%b %h_%h want ill=0 %h_%h", Illegal, HI, LO, hi0, lo0);
    end
  endtask

  task automatic test_reset_abort();
    int done_seen;
    start_op(OP_MTHI, 32'h7777_0000, 32'h0);
    start_op(OP_MULT, 32'd5, 32'd6);
    repeat (9) step_cycle();
    @(negedge Clock); Reset = 1'b1;
    step_cycle();
    Reset = 1'b0;
    n_checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || {HI, LO} !== 64'h0) begin
      n_fail++; $display("FAIL reset_abort: got busy=%b done=%b %h_%h want 0 0 0_0", Busy, Done, HI, LO);
    end
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done === 1'b1) done_seen++;
      step_cycle();
    end
    n_checks++;
    if (done_seen !== 0 || {HI, LO} !== 64'h0) begin
      n_fail++; $display("FAIL reset_abort_no_done: got %0d done pulses %h_%h want 0 0_0", done_seen, HI, LO);
    end
    start_op(OP_MTLO, 32'h0000_1234, 32'h0);
    n_checks++;
    if (LO !== 32'h0000_1234) begin
      n_fail++; $display("FAIL reset_abort_mtlo: got %h want 00001234", LO);
    end
    // Reset and Start at the same edge: reset must win.
    start_op(OP_MTHI, 32'h5555_5555, 32'h0);
    @(negedge Clock);
    Reset = 1'b1; Start = 1'b1; Op = OP_MTHI; A = 32'h0000_BEEF;
    step_cycle();
    Reset = 1'b0; Start = 1'b0;
    n_checks++;
    if ({HI, LO} !== 64'h0 || Busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_vs_start: got busy=%b %h_%h want 0 0_0", Busy, HI, LO);
    end
  endtask

  task automatic test_busy_ignore();
    int bc, da;
    logic [31:0] hm, lm;
    start_op(OP_MULTU, 32'd3, 32'd5);
    repeat (4) step_cycle();
    start_op(OP_MTHI, 32'h0000_DEAD, 32'h0);
    n_checks++;
    if (Busy !== 1'b1 || HI !== 32'h0) begin
      n_fail++; $display("FAIL busy_ignore_mid: got busy=%b HI=%h want 1 00000000", Busy, HI);
    end
    wait_done(bc, da, hm, lm);
    n_checks++;
    if (da !== 28 || {HI, LO} !== 64'h0000_0000_0000_000F) begin
      n_fail++; $display("FAIL busy_ignore_result: got done@%0d %h_%h want done@28 00000000_0000000f", da, HI, LO);
    end
    step_cycle();
  endtask

  task automatic test_back_to_back();
    int bc, da;
    logic [31:0] hm, lm;
    start_op(OP_MULTU, 32'd10, 32'd20);
    wait_done(bc, da, hm, lm);
    step_cycle();
    start_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_checks++;
    if ({HI, LO} !== 64'h0000_0000_0000_00C8 || Busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: got busy=%b %h_%h want 1 00000000_000000c8", Busy, HI, LO);
    end
    wait_done(bc, da, hm, lm);
    n_checks++;
    if (da !== 33 || {HI, LO} !== 64'h0000_0000_0000_0001) begin
      n_fail++; $display("FAIL b2b_second: got done@%0d %h_%h want done@33 00000000_00000001", da, HI, LO);
    end
    step_cycle();
  endtask

  initial begin
    test_reset();
    test_mt();
    test_multu_latency();
    test_mult();
`ifdef MULDIV_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_illegal();
    test_reset_abort();
    test_busy_ignore();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
